// File: rtl/noc_node_adapter.sv
// Local-port adapter between a host valid/ready interface and one mesh router: TX FIFO with injection
// throttling, RX FIFO with overflow drop counting. Optional macro NOC_DEST_CHECK_EN adds RX dest filtering.
module noc_node_adapter #(
    parameter int NODE_ID  = 0,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [3:0]  tx_dest,
    input  logic [7:0]  tx_payload,
    input  logic        local_full,
    output logic [16:0] net_flit_o,
    input  logic [16:0] net_flit_i,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [3:0]  rx_src,
    output logic [7:0]  rx_payload,
`ifdef NOC_DEST_CHECK_EN
    output logic [7:0]  misroute_cnt,
`endif
    output logic [7:0]  rx_drop_cnt
);

    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam logic [TXW:0] TX_FULL = (TXW + 1)'(TX_DEPTH);
    localparam logic [RXW:0] RX_FULL = (RXW + 1)'(RX_DEPTH);

    logic [16:0]    txMem_q [TX_DEPTH];
    logic [TXW-1:0] txWrPtr_q, txRdPtr_q;
    logic [TXW:0]   txCount_q;
    logic [16:0]    netFlit_q;

    logic [11:0]    rxMem_q [RX_DEPTH];
    logic [RXW-1:0] rxWrPtr_q, rxRdPtr_q;
    logic [RXW:0]   rxCount_q;
    logic [7:0]     dropCnt_q;

    logic txPush, txPop;
    logic rxFlitValid, rxAccept, rxPop, rxPush, rxDrop;

    assign tx_ready = !rst && (txCount_q != TX_FULL);
    assign txPush   = tx_valid && tx_ready;
    assign txPop    = !local_full && (txCount_q != '0);

    // With the dest check enabled, a misrouted flit is rejected before it can reach the overflow logic,
    // so a single flit can never bump both counters.
`ifdef NOC_DEST_CHECK_EN
    logic       misroute;
    logic [7:0] misrouteCnt_q;
    assign misroute     = net_flit_i[16] && (net_flit_i[15:12] != 4'(NODE_ID));
    assign rxAccept     = net_flit_i[16] && !misroute;
    assign misroute_cnt = misrouteCnt_q;
`else
    assign rxAccept     = net_flit_i[16];
`endif
    assign rxFlitValid = rxAccept;
    assign rxPop       = rx_valid && rx_ready;
    assign rxPush      = rxFlitValid && ((rxCount_q != RX_FULL) || rxPop);
    assign rxDrop      = rxFlitValid && (rxCount_q == RX_FULL) && !rxPop;

    assign rx_valid    = (rxCount_q != '0);
    assign rx_src      = rxMem_q[rxRdPtr_q][11:8];
    assign rx_payload  = rxMem_q[rxRdPtr_q][7:0];
    assign rx_drop_cnt = dropCnt_q;
    assign net_flit_o  = netFlit_q;

    always_ff @(posedge clk) begin
        if (txPush) begin
            txMem_q[txWrPtr_q] <= {1'b1, tx_dest, 4'(NODE_ID), tx_payload};
        end
        if (rxPush) begin
            rxMem_q[rxWrPtr_q] <= net_flit_i[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txWrPtr_q <= '0;
            txRdPtr_q <= '0;
            txCount_q <= '0;
            netFlit_q <= '0;
        end else begin
            if (txPush) begin
                txWrPtr_q <= txWrPtr_q + TXW'(1);
            end
            if (txPop) begin
                txRdPtr_q <= txRdPtr_q + TXW'(1);
                netFlit_q <= txMem_q[txRdPtr_q];
            end else begin
                netFlit_q <= '0;
            end
            if (txPush && !txPop) begin
                txCount_q <= txCount_q + (TXW + 1)'(1);
            end else if (!txPush && txPop) begin
                txCount_q <= txCount_q - (TXW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxWrPtr_q <= '0;
            rxRdPtr_q <= '0;
            rxCount_q <= '0;
            dropCnt_q <= '0;
        end else begin
            if (rxPush) begin
                rxWrPtr_q <= rxWrPtr_q + RXW'(1);
            end
            if (rxPop) begin
                rxRdPtr_q <= rxRdPtr_q + RXW'(1);
            end
            if (rxPush && !rxPop) begin
                rxCount_q <= rxCount_q + (RXW + 1)'(1);
            end else if (!rxPush && rxPop) begin
                rxCount_q <= rxCount_q - (RXW + 1)'(1);
            end
            if (rxDrop && (dropCnt_q != 8'hFF)) begin
                dropCnt_q <= dropCnt_q + 8'd1;
            end
        end
    end

`ifdef NOC_DEST_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misrouteCnt_q <= '0;
        end else if (misroute && (misrouteCnt_q != 8'hFF)) begin
            misrouteCnt_q <= misrouteCnt_q + 8'd1;
        end
    end
`endif

endmodule
